reg_file_mp: RTL and testbench

- Parametrised successor to the 32x32 dual-read register file: configurable width, depth and read-port count.
- Adds registered reads with a valid strobe, byte-masked writes, write-to-read bypass, optional hardwired-zero entry 0, and a sequenced bulk-clear with busy indication.
- Sits in the datapath between decode (addresses) and ALU/writeback. Serves as the standard register storage for the next processor revision.

---
 rtl/rf_pkg.sv | 37 +++
 rtl/reg_file_mp_if.sv | 30 +++
 rtl/rf_clear_seq.sv | 66 ++++++
 rtl/reg_file_mp.sv | 103 ++++++++++
 tb/tb_reg_file_mp.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the reg_file_mp register file.
//   - default geometry constants
//   - clear-sequencer state encoding
//   - byte_merge(): byte-masked merge used by both the write and bypass paths
// Ports: none (package).
package rf_pkg;

   localparam int unsigned RF_DATA_WIDTH = 32;
   localparam int unsigned RF_DEPTH      = 32;
   localparam int unsigned RF_ADDR_WIDTH = 5;
   localparam int unsigned RF_NUM_RD     = 2;

   // byte_merge works on a fixed maximal width; callers extend their operands
   // and truncate the result, which keeps one function for every DATA_WIDTH
   // up to RF_MAX_WIDTH.
   localparam int unsigned RF_MAX_WIDTH  = 1024;
   localparam int unsigned RF_MAX_BYTES  = RF_MAX_WIDTH / 8;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } rf_state_e;

   function automatic logic [RF_MAX_WIDTH-1:0] byte_merge(
      input logic [RF_MAX_WIDTH-1:0] old_v,
      input logic [RF_MAX_WIDTH-1:0] new_v,
      input logic [RF_MAX_BYTES-1:0] mask
   );
      logic [RF_MAX_WIDTH-1:0] m;
      m = old_v;
      for (int unsigned b = 0; b < RF_MAX_BYTES; b++) begin
         if (mask[b]) m[b*8 +: 8] = new_v[b*8 +: 8];
      end
      return m;
   endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus interface of reg_file_mp.
//   master: drives READ/ADDR_R, WRITE/ADDR_W/DATA_W/WMASK, CLR;
//           receives DATA_R, RVALID, BUSY.
//   slave : the register file side (reverse directions).
interface reg_file_mp_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned NUM_RD     = 2
);
   logic                           READ;
   logic [NUM_RD*ADDR_WIDTH-1:0]   ADDR_R;
   logic [NUM_RD*DATA_WIDTH-1:0]   DATA_R;
   logic                           RVALID;
   logic                           WRITE;
   logic [ADDR_WIDTH-1:0]          ADDR_W;
   logic [DATA_WIDTH-1:0]          DATA_W;
   logic [DATA_WIDTH/8-1:0]        WMASK;
   logic                           CLR;
   logic                           BUSY;

   modport master (
      output READ, ADDR_R, WRITE, ADDR_W, DATA_W, WMASK, CLR,
      input  DATA_R, RVALID, BUSY
   );

   modport slave (
      input  READ, ADDR_R, WRITE, ADDR_W, DATA_W, WMASK, CLR,
      output DATA_R, RVALID, BUSY
   );
endinterface

// File: rtl/rf_clear_seq.sv
// Bulk-clear sequencer for reg_file_mp.
//   CLK, RST   : clock, asynchronous active-low reset
//   clr_i      : start request, honoured only in IDLE
//   busy_o     : high while CLEAR runs (DEPTH cycles)
//   clr_en_o   : zero entry clr_idx_o at the next edge
//   clr_idx_o  : entry being cleared, 0..DEPTH-1
module rf_clear_seq
   import rf_pkg::*;
#(
   parameter int unsigned DEPTH      = RF_DEPTH,
   parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  clr_i,
   output logic                  busy_o,
   output logic                  clr_en_o,
   output logic [ADDR_WIDTH-1:0] clr_idx_o
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

   rf_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      busy_o    = 1'b0;
      clr_en_o  = 1'b0;
      clr_idx_o = idx_q;
      case (state_q)
         IDLE: begin
            if (clr_i) begin
               state_d = CLEAR;
               idx_d   = '0;
            end
         end
         CLEAR: begin
            busy_o   = 1'b1;
            clr_en_o = 1'b1;
            if (idx_q == LAST_IDX) begin
               state_d = IDLE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file.
//   CLK, RST : clock, asynchronous active-low reset
//   bus      : reg_file_mp_if slave port
//              READ/ADDR_R  -> DATA_R/RVALID one cycle later (registered)
//              WRITE/ADDR_W/DATA_W/WMASK -> byte-masked write
//              CLR -> bulk clear, BUSY high while it runs
// Optional hardwired-zero entry 0 (ZERO_REG) and write-to-read forwarding
// (BYPASS). Out-of-range addresses read 0 and drop writes.
module reg_file_mp
   import rf_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
   parameter int unsigned DEPTH      = RF_DEPTH,
   parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
   parameter int unsigned NUM_RD     = RF_NUM_RD,
   parameter bit          ZERO_REG   = 1'b1,
   parameter bit          BYPASS     = 1'b1
) (
   input  logic CLK,
   input  logic RST,
   reg_file_mp_if.slave bus
);

   // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

   logic                         busy, clr_en;
   logic [ADDR_WIDTH-1:0]        clr_idx;

   logic [DATA_WIDTH-1:0]        mem_q [DEPTH];
   logic [NUM_RD*DATA_WIDTH-1:0] data_r_q, data_r_d;
   logic                         rvalid_q;

   logic                         w_in_range, wr_en, rd_en;
   logic [DATA_WIDTH-1:0]        w_old, w_merged;
   logic [ADDR_WIDTH-1:0]        ra;
   logic [DATA_WIDTH-1:0]        rv;

   rf_clear_seq #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_seq (
      .CLK       (CLK),
      .RST       (RST),
      .clr_i     (bus.CLR),
      .busy_o    (busy),
      .clr_en_o  (clr_en),
      .clr_idx_o (clr_idx)
   );

   // Write path; the merged word also feeds the bypass.
   always_comb begin
      w_in_range = ({1'b0, bus.ADDR_W} < DEPTH_L);
      w_old      = w_in_range ? mem_q[bus.ADDR_W] : '0;
      w_merged   = DATA_WIDTH'(byte_merge(RF_MAX_WIDTH'(w_old),
                                          RF_MAX_WIDTH'(bus.DATA_W),
                                          RF_MAX_BYTES'(bus.WMASK)));
      wr_en      = bus.WRITE && !busy && w_in_range &&
                   !(ZERO_REG && (bus.ADDR_W == '0));
      rd_en      = bus.READ && !busy;
   end

   // Read path. Zero-entry masking is applied last so it also wins over bypass.
   always_comb begin
      data_r_d = '0;
      ra       = '0;
      rv       = '0;
      for (int unsigned k = 0; k < NUM_RD; k++) begin
         ra = bus.ADDR_R[k*ADDR_WIDTH +: ADDR_WIDTH];
         rv = '0;
         if ({1'b0, ra} < DEPTH_L)                  rv = mem_q[ra];
         if (BYPASS && wr_en && (ra == bus.ADDR_W)) rv = w_merged;
         if (ZERO_REG && (ra == '0))                rv = '0;
         data_r_d[k*DATA_WIDTH +: DATA_WIDTH] = rv;
      end
   end

   // Clear and write are mutually exclusive: writes are blocked while busy.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (clr_en) begin
         mem_q[clr_idx] <= '0;
      end else if (wr_en) begin
         mem_q[bus.ADDR_W] <= w_merged;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         data_r_q <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= rd_en;
         if (rd_en) data_r_q <= data_r_d;
      end
   end

   assign bus.DATA_R = data_r_q;
   assign bus.RVALID = rvalid_q;
   assign bus.BUSY   = busy;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp. Two instances share stimulus:
//   dut_a: DEPTH=32, BYPASS=1, ZERO_REG=1
//   dut_b: DEPTH=24, BYPASS=0, ZERO_REG=1
module tb_reg_file_mp;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   reg_file_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2)) ifa ();
   reg_file_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2)) ifb ();

   reg_file_mp #(.DATA_WIDTH(32), .DEPTH(32), .ADDR_WIDTH(5), .NUM_RD(2),
                 .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (.CLK(CLK), .RST(RST), .bus(ifa));
   reg_file_mp #(.DATA_WIDTH(32), .DEPTH(24), .ADDR_WIDTH(5), .NUM_RD(2),
                 .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_b (.CLK(CLK), .RST(RST), .bus(ifb));

   typedef struct {
      logic        rd;
      logic [4:0]  a0, a1;
      logic        wr;
      logic [4:0]  aw;
      logic [31:0] dw;
      logic [3:0]  wm;
      logic        ev;
      logic [31:0] ea0, ea1, eb0, eb1;
   } vec_t;

   int n_cmp = 0;
   int n_err = 0;

   function automatic vec_t mk(logic rd, logic [4:0] a0, logic [4:0] a1,
                               logic wr, logic [4:0] aw, logic [31:0] dw, logic [3:0] wm,
                               logic ev, logic [31:0] ea0, logic [31:0] ea1,
                               logic [31:0] eb0, logic [31:0] eb1);
      vec_t v;
      v.rd = rd; v.a0 = a0; v.a1 = a1; v.wr = wr; v.aw = aw; v.dw = dw; v.wm = wm;
      v.ev = ev; v.ea0 = ea0; v.ea1 = ea1; v.eb0 = eb0; v.eb1 = eb1;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rd, input logic [4:0] a0, input logic [4:0] a1,
                        input logic wr, input logic [4:0] aw, input logic [31:0] dw,
                        input logic [3:0] wm, input logic clr);
      ifa.READ = rd; ifa.ADDR_R = {a1, a0}; ifa.WRITE = wr; ifa.ADDR_W = aw;
      ifa.DATA_W = dw; ifa.WMASK = wm; ifa.CLR = clr;
      ifb.READ = rd; ifb.ADDR_R = {a1, a0}; ifb.WRITE = wr; ifb.ADDR_W = aw;
      ifb.DATA_W = dw; ifb.WMASK = wm; ifb.CLR = clr;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
   endtask

   // Inputs change on the falling edge; outputs are sampled on the next one.
   task automatic step();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic chk_rd(input string nm, input logic ev,
                         input logic [31:0] ea0, input logic [31:0] ea1,
                         input logic [31:0] eb0, input logic [31:0] eb1);
      chk({nm, " A.rvalid"}, 64'(ifa.RVALID), 64'(ev));
      chk({nm, " B.rvalid"}, 64'(ifb.RVALID), 64'(ev));
      chk({nm, " A.d0"}, 64'(ifa.DATA_R[31:0]),  64'(ea0));
      chk({nm, " A.d1"}, 64'(ifa.DATA_R[63:32]), 64'(ea1));
      chk({nm, " B.d0"}, 64'(ifb.DATA_R[31:0]),  64'(eb0));
      chk({nm, " B.d1"}, 64'(ifb.DATA_R[63:32]), 64'(eb1));
   endtask

   // Runs from the falling edge right after the CLR edge until both BUSY drop.
   // With traffic=1, a READ/WRITE/CLR is injected mid-clear and must be ignored.
   task automatic count_busy(input string nm, input logic traffic);
      int  cnt_a = 0;
      int  cnt_b = 0;
      logic done = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
         if (c > 0) step();
         if (ifa.BUSY) cnt_a++;
         if (ifb.BUSY) cnt_b++;
         if (traffic && c == 6) begin
            chk({nm, " busy-read A.rvalid"}, 64'(ifa.RVALID), 64'(0));
            chk({nm, " busy-read B.rvalid"}, 64'(ifb.RVALID), 64'(0));
         end
         // entry 2 is already cleared at this point, so an accepted write would stick
         if (traffic && c == 5) drive(1'b1, 5'd2, 5'd3, 1'b1, 5'd2, 32'hFFFF_FFFF, 4'hF, 1'b1);
         else idle();
         if (!ifa.BUSY && !ifb.BUSY) done = 1'b1;
      end
      chk({nm, " busy-ends"}, 64'(done), 64'(1));
      chk({nm, " A.busy-cycles"}, 64'(cnt_a), 64'(32));
      chk({nm, " B.busy-cycles"}, 64'(cnt_b), 64'(24));
   endtask

   vec_t vt[16];

   initial begin
      vt[0]  = mk(1, 5'd5, 5'd0,  0, 5'd0,  32'h0,        4'h0, 1, 32'h0,        32'h0,        32'h0,        32'h0);
      vt[1]  = mk(0, 5'd0, 5'd0,  0, 5'd0,  32'h0,        4'h0, 0, 32'h0,        32'h0,        32'h0,        32'h0);
      vt[2]  = mk(0, 5'd0, 5'd0,  1, 5'd7,  32'hDEADBEEF, 4'hF, 0, 32'h0,        32'h0,        32'h0,        32'h0);
      vt[3]  = mk(0, 5'd0, 5'd0,  1, 5'd7,  32'h000000AA, 4'h1, 0, 32'h0,        32'h0,        32'h0,        32'h0);
      vt[4]  = mk(1, 5'd7, 5'd0,  0, 5'd0,  32'h0,        4'h0, 1, 32'hDEADBEAA, 32'h0,        32'hDEADBEAA, 32'h0);
      vt[5]  = mk(0, 5'd0, 5'd0,  1, 5'd3,  32'h11111111, 4'hF, 0, 32'hDEADBEAA, 32'h0,        32'hDEADBEAA, 32'h0);
      vt[6]  = mk(1, 5'd3, 5'd4,  1, 5'd3,  32'h22222222, 4'hC, 1, 32'h22221111, 32'h0,        32'h11111111, 32'h0);
      vt[7]  = mk(1, 5'd3, 5'd4,  0, 5'd0,  32'h0,        4'h0, 1, 32'h22221111, 32'h0,        32'h22221111, 32'h0);
      vt[8]  = mk(1, 5'd0, 5'd3,  1, 5'd0,  32'hFFFFFFFF, 4'hF, 1, 32'h0,        32'h22221111, 32'h0,        32'h22221111);
      vt[9]  = mk(1, 5'd0, 5'd0,  0, 5'd0,  32'h0,        4'h0, 1, 32'h0,        32'h0,        32'h0,        32'h0);
      vt[10] = mk(1, 5'd30, 5'd3, 1, 5'd30, 32'h12345678, 4'hF, 1, 32'h12345678, 32'h22221111, 32'h0,        32'h22221111);
      vt[11] = mk(1, 5'd30, 5'd7, 0, 5'd0,  32'h0,        4'h0, 1, 32'h12345678, 32'hDEADBEAA, 32'h0,        32'hDEADBEAA);
      vt[12] = mk(1, 5'd5, 5'd31, 1, 5'd5,  32'hAABBCCDD, 4'h0, 1, 32'h0,        32'h0,        32'h0,        32'h0);
      vt[13] = mk(1, 5'd3, 5'd4,  1, 5'd4,  32'hCAFEF00D, 4'hF, 1, 32'h22221111, 32'hCAFEF00D, 32'h22221111, 32'h0);
      vt[14] = mk(1, 5'd4, 5'd4,  0, 5'd0,  32'h0,        4'h0, 1, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D);
      vt[15] = mk(1, 5'd6, 5'd14, 0, 5'd0,  32'h0,        4'h0, 1, 32'h0,        32'h0,        32'h0,        32'h0);

      // reset state
      idle();
      #1 RST = 1'b0;
      #2;
      chk("reset A.busy", 64'(ifa.BUSY), 64'(0));
      chk("reset B.busy", 64'(ifb.BUSY), 64'(0));
      chk_rd("reset", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      @(negedge CLK);
      RST = 1'b1;

      // directed vector table
      for (int i = 0; i < 16; i++) begin
         drive(vt[i].rd, vt[i].a0, vt[i].a1, vt[i].wr, vt[i].aw, vt[i].dw, vt[i].wm, 1'b0);
         step();
         chk_rd($sformatf("vec%0d", i), vt[i].ev, vt[i].ea0, vt[i].ea1, vt[i].eb0, vt[i].eb1);
      end

      // fill every entry with nonzero data
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 5'd0, 5'd0, 1'b1, 5'(i), 32'hA500_0000 | 32'(i), 4'hF, 1'b0);
         step();
      end

      // CLR together with READ/WRITE: both performed, then the clear runs
      drive(1'b1, 5'd20, 5'd1, 1'b1, 5'd20, 32'h0000005A, 4'hF, 1'b1);
      step();
      chk_rd("clr+rw", 1'b1, 32'h0000005A, 32'hA5000001, 32'hA5000014, 32'hA5000001);
      chk("clr A.busy-start", 64'(ifa.BUSY), 64'(1));
      chk("clr B.busy-start", 64'(ifb.BUSY), 64'(1));
      count_busy("clear1", 1'b1);

      // every entry reads back zero after the clear
      for (int i = 0; i < 32; i++) begin
         drive(1'b1, 5'(i), 5'(31 - i), 1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
         step();
         chk_rd($sformatf("post-clear%0d", i), 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
      end

      // asynchronous reset in the middle of a clear
      drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 32'h00000099, 4'hF, 1'b0);
      step();
      drive(1'b1, 5'd9, 5'd9, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1);
      step();
      chk_rd("pre-abort", 1'b1, 32'h99, 32'h99, 32'h99, 32'h99);
      idle();
      for (int c = 0; c < 10; c++) step();
      chk("abort A.busy-before", 64'(ifa.BUSY), 64'(1));
      #2 RST = 1'b0;
      #1;
      chk("abort A.busy", 64'(ifa.BUSY), 64'(0));
      chk("abort B.busy", 64'(ifb.BUSY), 64'(0));
      chk_rd("abort", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      @(negedge CLK);
      RST = 1'b1;
      drive(1'b1, 5'd9, 5'd10, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
      step();
      chk_rd("after-abort", 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1);
      step();
      count_busy("clear2", 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
